// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: fetch PC, IM request, instruction buffer
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instruction,
  output logic [31:0] id_npc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  // While a request is in flight, r_fetch_pc already holds that request's
  // address + 4, so it doubles as the npc recorded for the response.
  logic [31:0]      r_fetch_pc;
  logic             r_inflight;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [31:0]      r_buf_instr [DEPTH];
  logic [31:0]      r_buf_npc   [DEPTH];

  logic [31:0]      w_target;
  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic [CNT_W:0]   w_occ_after_pop;
  logic             w_unused;

  // Low address bits of the redirect target are ignored.
  assign w_target = {redirect_pc[31:2], 2'b00};
  assign w_unused = ^redirect_pc[1:0];

  assign id_valid       = (r_count != '0);
  assign id_instruction = id_valid ? r_buf_instr[r_head] : 32'h0000_0000;
  assign id_npc         = id_valid ? r_buf_npc[r_head]   : 32'h0000_0000;

  // A redirect discards the head and any response arriving this cycle.
  assign w_pop  = id_valid & id_ready & ~redirect;
  assign w_push = r_inflight & ~redirect;

  // Pop implies count >= 1, so this never underflows.
  assign w_occ_after_pop = {1'b0, r_count}
                         + {{CNT_W{1'b0}}, r_inflight}
                         - {{CNT_W{1'b0}}, w_pop};

  // Only issue when the response is guaranteed a free slot; a redirect always refetches.
  assign w_issue = ~reset & (redirect | (w_occ_after_pop < DEPTH_C));
  assign im_req  = w_issue;
  assign im_addr = redirect ? w_target : r_fetch_pc;

  // Fetch PC, in-flight flag and buffer pointers/occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else if (redirect) begin
      r_fetch_pc <= w_target + 32'd4;
      r_inflight <= 1'b1;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Buffer storage: capture the memory response with its npc at the tail.
  always_ff @(posedge clock) begin
    if (!reset && w_push) begin
      r_buf_instr[r_tail] <= im_rdata;
      r_buf_npc[r_tail]   <= r_fetch_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;

  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_npc;

  logic        x_im_req;
  logic [31:0] x_im_addr;
  logic [31:0] x_im_rdata;
  logic        x_id_valid;
  logic [31:0] x_id_instruction;
  logic [31:0] x_id_npc;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
    .clock(clock), .reset(reset),
    .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid),
    .id_instruction(id_instruction), .id_npc(id_npc)
  );

  fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(2)) u_wrap (
    .clock(clock), .reset(reset),
    .im_req(x_im_req), .im_addr(x_im_addr), .im_rdata(x_im_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(x_id_valid),
    .id_instruction(x_id_instruction), .id_npc(x_id_npc)
  );

  // Instruction memory models: instruction word equals its address, one-cycle latency.
  always @(posedge clock) begin
    im_rdata   <= im_req   ? im_addr   : 32'hDEAD_BEEF;
    x_im_rdata <= x_im_req ? x_im_addr : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic chkb(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
  endtask

  task automatic sb_load(input logic [31:0] start);
    exp_t e;
    sb.delete();
    for (int i = 0; i < 64; i++) begin
      e.instr = start + 32'(4 * i);
      e.npc   = start + 32'(4 * i + 4);
      sb.push_back(e);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    if (!reset && !redirect && id_ready && id_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chkb("sb_extra", id_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("sb_instr", id_instruction, e.instr);
        chk("sb_npc", id_npc, e.npc);
      end
    end
  endtask

  task automatic cyc();
    sb_check();
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_ready    = 1'b1;
    @(posedge clock);
    #2;

    // reset state
    #1;
    chkb("rst_im_req", im_req, 1'b0);
    chkb("rst_valid", id_valid, 1'b0);
    chk("rst_instr", id_instruction, 32'h0);
    chk("rst_npc", id_npc, 32'h0);
    cyc();

    // streaming with id_ready high, plus the wrapping instance
    sb_load(32'h0000_0000);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chkb("p1_im_req", im_req, 1'b1);
      chk("p1_im_addr", im_addr, 32'(4 * k));
      chkb("p1_valid", id_valid, k >= 2);
      if (k < 3) chk("wrap_addr", x_im_addr, WRAP_PC + 32'(4 * k));
      if (k >= 2 && k < 5) begin
        chk("wrap_instr", x_id_instruction, WRAP_PC + 32'(4 * (k - 2)));
        chk("wrap_npc", x_id_npc, WRAP_PC + 32'(4 * (k - 1)));
      end
      cyc();
    end

    // stall for 5 cycles
    id_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chkb("stall_im_req", im_req, 1'b0);
      chkb("stall_valid", id_valid, 1'b1);
      chk("stall_hold", id_instruction, sb[0].instr);
      cyc();
    end
    id_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chkb("resume_valid", id_valid, 1'b1);
      if (k == 0) chkb("resume_im_req", im_req, 1'b1);
      cyc();
    end

    // redirect with a request in flight and a non-empty buffer
    #1;
    chkb("pre_redir_valid", id_valid, 1'b1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    sb_load(32'h0000_0100);
    #1;
    chkb("redir_im_req", im_req, 1'b1);
    chk("redir_im_addr", im_addr, 32'h0000_0100);
    cyc();
    redirect    = 1'b0;
    redirect_pc = 32'hABCD_0000;
    #1;
    chkb("redir_gap", id_valid, 1'b0);
    cyc();
    #1;
    chkb("redir_valid", id_valid, 1'b1);
    chk("redir_instr", id_instruction, 32'h0000_0100);
    chk("redir_npc", id_npc, 32'h0000_0104);
    for (int k = 0; k < 4; k++) begin
      #1;
      chkb("redir_stream", id_valid, 1'b1);
      cyc();
    end

    // redirect while stalled and full
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) cyc();
    #1;
    chkb("full_im_req", im_req, 1'b0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0203;
    sb_load(32'h0000_0200);
    #1;
    chkb("sredir_im_req", im_req, 1'b1);
    chk("sredir_im_addr", im_addr, 32'h0000_0200);
    cyc();
    redirect    = 1'b0;
    redirect_pc = 32'h1234_5678;
    #1;
    chkb("sredir_gap", id_valid, 1'b0);
    cyc();
    #1;
    chkb("sredir_valid", id_valid, 1'b1);
    chk("sredir_instr", id_instruction, 32'h0000_0200);
    chk("sredir_npc", id_npc, 32'h0000_0204);
    cyc();
    id_ready = 1'b1;
    for (int k = 0; k < 5; k++) cyc();

    // reset mid-stream with redirect high
    reset       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    sb_load(32'h0000_0000);
    #1;
    chkb("mrst_im_req", im_req, 1'b0);
    cyc();
    redirect = 1'b0;
    #1;
    chkb("mrst_next_req", im_req, 1'b0);
    chkb("mrst_next_valid", id_valid, 1'b0);
    chk("mrst_next_instr", id_instruction, 32'h0);
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chkb("restart_im_req", im_req, 1'b1);
      chk("restart_im_addr", im_addr, 32'(4 * k));
      chkb("restart_valid", id_valid, k >= 2);
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the five-stage pipeline CPU. Owns the fetch PC, drives a synchronous instruction memory with a one-cycle read latency, and buffers returned instructions in a small FIFO. It presents them to the IF-ID register through a valid/ready handshake. Handles ID stalls through backpressure and branch or jump redirects through a flush. It replaces the free-running PC+IM pair in front of the IF-ID register.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded on reset; bits [1:0] must be 0
- DEPTH, 2, instruction buffer entries; power of two, at least 2
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- im_req  out  1  read request to instruction memory this cycle
- im_addr  out  32  word-aligned read address; meaningful only when im_req=1
- im_rdata  in  32  instruction for the request issued in the previous cycle
- redirect  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0)
- id_ready  in  1  IF-ID register can accept this cycle (low = ID stall)
- id_valid  out  1  buffer head holds a valid instruction
- id_instruction  out  32  head instruction; 32'h0000_0000 (NOP) when id_valid=0
- id_npc  out  32  head instruction's PC+4; 0 when id_valid=0

## Operation
- State
  - fetch_pc: 32 bits.
  - FIFO: DEPTH entries of {instruction, npc}, with head and tail pointers and a count of 0..DEPTH.
  - inflight: 1 bit, set when a request was issued last cycle.
- pop = id_valid & id_ready & !redirect.
- occupancy = count + inflight.
- Issue rule, normal cycle: im_req = 1 when (occupancy - pop) < DEPTH.
  - im_addr = fetch_pc.
  - On issue: fetch_pc <= fetch_pc + 4, mod 2^32, so 32'hFFFF_FFFC wraps to 0.
  - The npc recorded for the request is im_addr + 4.
- Response: when inflight = 1 and there is no redirect this cycle, {im_rdata, recorded npc} is written at tail.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Redirect cycle (takes priority over everything):
  - FIFO is emptied (count <= 0, pointers reset).
  - The head is discarded even if id_ready=1. The ID stage squashes its own capture on redirect.
  - An in-flight response arriving this cycle is dropped.
  - im_req = 1 with im_addr = {redirect_pc[31:2], 2'b00}.
  - fetch_pc <= that address + 4.
  - inflight <= 1.
- Never issue when the buffer could overflow. No instruction may be lost or duplicated under any id_ready pattern.
- im_rdata is sampled only when inflight = 1; it is don't-care otherwise.

## Timing
- Reset, asserted at a rising edge:
  - fetch_pc = RESET_PC, count = 0, inflight = 0.
  - In the following cycle: id_valid = 0, id_instruction = 0, id_npc = 0.
  - im_req = 0 in every cycle where reset is high.
- First cycle after reset deasserts: im_req = 1, im_addr = RESET_PC.
- Fetch latency:
  - A request issued in cycle N is written at the end of N+1.
  - It is visible as id_valid in N+2.
  - No bypass from im_rdata to the id_* outputs.
- Throughput: with id_ready held at 1, one instruction per cycle after the two-cycle fill, for any DEPTH ≥ 2.
- Stall: with id_ready = 0, im_req drops once occupancy reaches DEPTH. The outputs hold stable until id_ready returns.
- Redirect:
  - Redirect in cycle R issues the target in R.
  - The target is presented in R+2.
  - id_valid = 0 in R+1.
- Reset mid-operation: all state is cleared on that edge regardless of redirect, inflight or FIFO contents. Any response in the next cycle is ignored.

## Test plan
- Reset, then id_ready = 1 held with IM holding instruction = address:
  - im_addr = 0, 4, 8, ... on consecutive cycles.
  - id_valid first high 2 cycles after reset release, with id_instruction = 0 and id_npc = 4.
  - Then one instruction per cycle in order.
- Stall: drop id_ready for 5 cycles mid-stream.
  - im_req low once occupancy = DEPTH.
  - id_instruction held constant during the stall.
  - After release, the sequence continues with no gap, loss or duplicate.
- Redirect to 32'h0000_0102 while a request is in flight and the FIFO is non-empty:
  - im_addr = 0x100 in the same cycle.
  - Old entries and the in-flight response are never presented.
  - Next id_valid shows instruction 0x100 with id_npc = 0x104, two cycles later.
- Redirect while stalled and full, with id_ready = 0: same flush behaviour; the target appears two cycles later.
- Wrap: RESET_PC = 32'hFFFF_FFF8.
  - Fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
  - id_npc values are 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- Reset asserted mid-stream with redirect also high:
  - Next cycle: id_valid = 0, im_req = 0.
  - After release, fetching restarts at RESET_PC.
